// File: rtl/regfile_mp.sv
// regfile_mp: parametrised register file with NRD combinational read ports,
// two write lanes (lane 1 has priority), same-cycle write-through bypass,
// optional hardwired zero register and a per-register pending scoreboard.
module regfile_mp #(
    parameter int WIDTH    = 32,
    parameter int DEPTH    = 32,
    parameter int AW       = $clog2(DEPTH),
    parameter int NRD      = 2,
    parameter int ZERO_REG = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NRD*AW-1:0]      rd_reg,
    output logic [NRD*WIDTH-1:0]   dout,
    output logic [NRD-1:0]         rd_busy,
    input  logic [1:0]             wr_en,
    input  logic [2*AW-1:0]        wr_reg,
    input  logic [2*WIDTH-1:0]     din,
    input  logic                   pend_set,
    input  logic [AW-1:0]          pend_reg,
    output logic [DEPTH-1:0]       pend,
    output logic [AW:0]            pend_cnt,
    output logic [DEPTH*WIDTH-1:0] regOut
);

    logic [WIDTH-1:0] regs [DEPTH];
    logic [AW-1:0]    wa [2];
    logic [WIDTH-1:0] wd [2];
    logic [1:0]       we_commit;
    logic [DEPTH-1:0] pend_next;
    logic [AW:0]      cnt_next;

    // Split the packed write lanes; writes aimed at the zero register never commit.
    always_comb begin
        for (int j = 0; j < 2; j++) begin
            wa[j]        = wr_reg[j*AW +: AW];
            wd[j]        = din[j*WIDTH +: WIDTH];
            we_commit[j] = wr_en[j] && !(ZERO_REG != 0 && wa[j] == '0);
        end
    end

    // Next scoreboard state: writes retire producers, a new pend_set (younger) wins.
    always_comb begin
        pend_next = pend;
        for (int j = 0; j < 2; j++) begin
            if (wr_en[j]) pend_next[wa[j]] = 1'b0;
        end
        if (pend_set) pend_next[pend_reg] = 1'b1;
        if (ZERO_REG != 0) pend_next[0] = 1'b0;
        cnt_next = '0;
        for (int i = 0; i < DEPTH; i++) begin
            cnt_next = cnt_next + (AW+1)'(pend_next[i]);
        end
    end

    // Storage and scoreboard update; lane 1 is assigned last so it wins a collision.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
            pend     <= '0;
            pend_cnt <= '0;
        end else begin
            if (we_commit[0]) regs[wa[0]] <= wd[0];
            if (we_commit[1]) regs[wa[1]] <= wd[1];
            pend     <= pend_next;
            pend_cnt <= cnt_next;
        end
    end

    // Read ports with write-through bypass (disabled during reset) and busy flags.
    always_comb begin
        logic [AW-1:0]    addr;
        logic [WIDTH-1:0] data;
        logic             hit0;
        logic             hit1;
        dout    = '0;
        rd_busy = '0;
        for (int k = 0; k < NRD; k++) begin
            addr = rd_reg[k*AW +: AW];
            hit0 = rst_n && wr_en[0] && (wa[0] == addr);
            hit1 = rst_n && wr_en[1] && (wa[1] == addr);
            data = regs[addr];
            if (hit1) begin
                data = wd[1];
            end else if (hit0) begin
                data = wd[0];
            end
            if (ZERO_REG != 0 && addr == '0) data = '0;
            dout[k*WIDTH +: WIDTH] = data;
            rd_busy[k]             = pend[addr] && !(hit0 || hit1);
        end
    end

    // Flatten stored contents (no bypass) onto regOut.
    for (genvar g = 0; g < DEPTH; g++) begin : g_regout
        assign regOut[g*WIDTH +: WIDTH] = regs[g];
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Testbench for regfile_mp: a driver applies one stimulus per cycle, derives the
// expected outputs from an array-based reference model and queues them; a monitor
// on the falling edge pops and compares against the DUT.
module tb_regfile_mp;

    localparam int WIDTH = 32;
    localparam int DEPTH = 32;
    localparam int AW    = 5;
    localparam int NRD   = 2;

    logic                   clk;
    logic                   rst_n;
    logic [NRD*AW-1:0]      rd_reg;
    logic [NRD*WIDTH-1:0]   dout;
    logic [NRD-1:0]         rd_busy;
    logic [1:0]             wr_en;
    logic [2*AW-1:0]        wr_reg;
    logic [2*WIDTH-1:0]     din;
    logic                   pend_set;
    logic [AW-1:0]          pend_reg;
    logic [DEPTH-1:0]       pend;
    logic [AW:0]            pend_cnt;
    logic [DEPTH*WIDTH-1:0] regOut;

    regfile_mp #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW), .NRD(NRD), .ZERO_REG(1)) dut (
        .clk(clk), .rst_n(rst_n), .rd_reg(rd_reg), .dout(dout), .rd_busy(rd_busy),
        .wr_en(wr_en), .wr_reg(wr_reg), .din(din), .pend_set(pend_set),
        .pend_reg(pend_reg), .pend(pend), .pend_cnt(pend_cnt), .regOut(regOut)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [NRD-1:0][WIDTH-1:0] dout;
        logic [NRD-1:0]            busy;
        logic                      chk_busy;
        logic [DEPTH*WIDTH-1:0]    regs;
        logic [DEPTH-1:0]          pend;
        logic [AW:0]               cnt;
    } exp_t;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;

    // Reference model state
    logic [WIDTH-1:0] m_reg [DEPTH];
    logic [DEPTH-1:0] m_pend;

    task automatic chk(input string nm, input int idx, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[%0d] actual=%0h required=%0h at %0t", nm, idx, act, exp, $time);
        end
    endtask

    // One clock of stimulus; expected outputs come from the model's current state,
    // then the model advances to the state the coming edge should produce.
    task automatic cyc(input logic r, input logic [1:0] we,
                       input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                       input logic [WIDTH-1:0] d0, input logic [WIDTH-1:0] d1,
                       input logic ps, input logic [AW-1:0] pr,
                       input logic [AW-1:0] r0, input logic [AW-1:0] r1, input bit push);
        exp_t e;
        logic [AW-1:0] ra;
        @(posedge clk);
        #1;
        rst_n    = r;
        wr_en    = we;
        wr_reg   = {a1, a0};
        din      = {d1, d0};
        pend_set = ps;
        pend_reg = pr;
        rd_reg   = {r1, r0};
        if (push) begin
            e = '0;
            for (int k = 0; k < NRD; k++) begin
                ra = (k == 0) ? r0 : r1;
                if (ra == 0)                     e.dout[k] = '0;
                else if (r && we[1] && a1 == ra) e.dout[k] = d1;
                else if (r && we[0] && a0 == ra) e.dout[k] = d0;
                else                             e.dout[k] = m_reg[ra];
                e.busy[k] = m_pend[ra] && !((we[0] && a0 == ra) || (we[1] && a1 == ra));
            end
            e.chk_busy = r;
            for (int i = 0; i < DEPTH; i++) e.regs[i*WIDTH +: WIDTH] = m_reg[i];
            e.pend = m_pend;
            e.cnt  = (AW+1)'($countones(m_pend));
            q.push_back(e);
        end
        if (!r) begin
            for (int i = 0; i < DEPTH; i++) m_reg[i] = '0;
            m_pend = '0;
        end else begin
            if (we[0] && a0 != 0) m_reg[a0] = d0;
            if (we[1] && a1 != 0) m_reg[a1] = d1;
            if (we[0]) m_pend[a0] = 1'b0;
            if (we[1]) m_pend[a1] = 1'b0;
            if (ps && pr != 0) m_pend[pr] = 1'b1;
        end
    endtask

    task automatic idle(input logic [AW-1:0] r0, input logic [AW-1:0] r1);
        cyc(1'b1, 2'b00, '0, '0, '0, '0, 1'b0, '0, r0, r1, 1'b1);
    endtask

    // Monitor: every cycle the DUT presents a full output set; compare with the queue head.
    always @(negedge clk) begin
        exp_t e;
        if (q.size() > 0) begin
            e = q.pop_front();
            for (int k = 0; k < NRD; k++) begin
                chk("dout", k, 64'(dout[k*WIDTH +: WIDTH]), 64'(e.dout[k]));
                if (e.chk_busy) chk("rd_busy", k, 64'(rd_busy[k]), 64'(e.busy[k]));
            end
            for (int i = 0; i < DEPTH; i++) begin
                chk("regOut", i, 64'(regOut[i*WIDTH +: WIDTH]), 64'(e.regs[i*WIDTH +: WIDTH]));
            end
            chk("pend", 0, 64'(pend), 64'(e.pend));
            chk("pend_cnt", 0, 64'(pend_cnt), 64'(e.cnt));
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1);
    end

    initial begin
        logic [WIDTH-1:0] d;
        rst_n = 1'b0; wr_en = '0; wr_reg = '0; din = '0;
        pend_set = 1'b0; pend_reg = '0; rd_reg = '0;
        for (int i = 0; i < DEPTH; i++) m_reg[i] = '0;
        m_pend = '0;

        // Reset: first edge clears X state, second cycle checks the reset values.
        cyc(1'b0, 2'b00, '0, '0, '0, '0, 1'b0, '0, '0, '0, 1'b0);
        cyc(1'b0, 2'b11, 5'd4, 5'd6, 32'hDEAD, 32'hBEEF, 1'b1, 5'd4, 5'd4, 5'd6, 1'b1);

        // Fill every register through lane 0 while reading it back on both ports.
        for (int i = 0; i < DEPTH; i++) begin
            d = $urandom;
            cyc(1'b1, 2'b01, AW'(i), '0, d, '0, 1'b0, '0, AW'(i), AW'(i), 1'b1);
        end

        // Exhaustive read sweep with no writes.
        for (int a = 0; a < DEPTH; a++) begin
            for (int b = 0; b < DEPTH; b++) begin
                idle(AW'(a), AW'(b));
            end
        end

        // Lane collision on register 5.
        cyc(1'b1, 2'b11, 5'd5, 5'd5, 32'hAAAA0000, 32'h5555FFFF, 1'b0, '0, 5'd5, 5'd5, 1'b1);
        idle(5'd5, 5'd0);

        // Scoreboard set, then clear via a lane-0 write with bypass.
        cyc(1'b1, 2'b00, '0, '0, '0, '0, 1'b1, 5'd7, 5'd7, 5'd3, 1'b1);
        idle(5'd3, 5'd7);
        cyc(1'b1, 2'b01, 5'd7, '0, 32'h1234, '0, 1'b0, '0, 5'd7, 5'd7, 1'b1);
        idle(5'd7, 5'd7);

        // Set/clear race on register 9: set wins, data still written.
        cyc(1'b1, 2'b01, 5'd9, '0, 32'hC0FFEE09, '0, 1'b1, 5'd9, 5'd9, 5'd1, 1'b1);
        idle(5'd9, 5'd9);

        // pend_set to register 0 is dropped.
        cyc(1'b1, 2'b00, '0, '0, '0, '0, 1'b1, 5'd0, 5'd0, 5'd0, 1'b1);
        idle(5'd0, 5'd9);

        // Randomised traffic with occasional resets.
        for (int n = 0; n < 400; n++) begin
            cyc(($urandom_range(0, 39) != 0), 2'($urandom), AW'($urandom), AW'($urandom),
                $urandom, $urandom, ($urandom_range(0, 2) == 0), AW'($urandom),
                AW'($urandom), AW'($urandom), 1'b1);
        end

        // Mid-operation reset with writes in flight and pend[3] set.
        for (int i = 1; i < DEPTH; i++) begin
            d = $urandom;
            cyc(1'b1, 2'b01, AW'(i), '0, d, '0, 1'b0, '0, AW'(i), '0, 1'b1);
        end
        cyc(1'b1, 2'b00, '0, '0, '0, '0, 1'b1, 5'd3, 5'd3, 5'd1, 1'b1);
        cyc(1'b0, 2'b11, 5'd1, 5'd2, 32'h11111111, 32'h22222222, 1'b1, 5'd8, 5'd1, 5'd2, 1'b1);
        idle(5'd1, 5'd3);
        idle(5'd2, 5'd8);

        @(negedge clk);
        @(negedge clk);
        chk("queue_drain", 0, 64'(q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-port register file: the next-generation replacement for the fixed 32x32, two-read/one-write register file in the CPU datapath. It adds configurable width, depth and read-port count, and two write ports with defined priority. It keeps same-cycle write-to-read bypass and adds an optional hardwired zero register, synchronous clear, and a per-register pending scoreboard so issue logic can stall on outstanding producers. It sits between decode/issue (read addresses, scoreboard set) and writeback (two retire lanes).

## Interface
- WIDTH, 32, data bits per register
- DEPTH, 32, number of registers (power of two, at least 2)
- AW, log2(DEPTH), register address width
- NRD, 2, number of read ports (1..4)
- ZERO_REG, 1, when 1 register 0 always reads 0, ignores writes and is never pending
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous, active-low reset
- rd_reg  input  NRD*AW  read addresses; port k is bits [k*AW +: AW]
- dout  output  NRD*WIDTH  read data; port k is bits [k*WIDTH +: WIDTH], combinational
- rd_busy  output  NRD  port k source register is pending and not bypassed this cycle
- wr_en  input  2  write enables for lanes 0 and 1
- wr_reg  input  2*AW  write addresses; lane j is bits [j*AW +: AW]
- din  input  2*WIDTH  write data; lane j is bits [j*WIDTH +: WIDTH]
- pend_set  input  1  mark pend_reg as having an outstanding producer
- pend_reg  input  AW  register to mark pending
- pend  output  DEPTH  registered scoreboard bits
- pend_cnt  output  AW+1  number of set bits in pend, registered
- regOut  output  DEPTH*WIDTH  stored contents (no bypass); register i is bits [i*WIDTH +: WIDTH]

## Operation
- Storage is DEPTH x WIDTH flops. Writes commit at the rising edge when wr_en[j]=1 and rst_n=1.
- Both lanes write the same register in the same cycle: lane 1 wins, because it is the younger instruction.
- Read port k: if wr_en[1] and wr_reg1==rd_reg_k, dout_k=din1; else if wr_en[0] and wr_reg0==rd_reg_k, dout_k=din0; else dout_k=stored value. This is the same-cycle write-through bypass.
- When ZERO_REG=1 and rd_reg_k==0, dout_k=0 regardless of bypass. Writes to register 0 are dropped. pend_set to register 0 is dropped.
- Scoreboard:
  - pend_set sets pend[pend_reg] at the edge.
  - A write on either lane clears pend[wr_reg] at the edge.
  - pend_set and a write to the same register in the same cycle: set wins, because the new producer is younger.
- rd_busy[k] = pend[rd_reg_k] and not (any write lane matches rd_reg_k this cycle).
- pend_cnt tracks the population of pend. It is updated in the same edge as pend and never exceeds DEPTH (or DEPTH-1 with ZERO_REG).
- Out-of-range addresses cannot occur, because DEPTH is a power of two.

## Timing
- Reset, when rst_n=0 at a rising edge:
  - All registers become 0; pend=0; pend_cnt=0.
  - wr_en and pend_set in that cycle are ignored.
  - While rst_n=0, bypass is disabled and dout reflects stored values.
  - A reset asserted mid-stream discards in-flight writes and pending state in the same edge.
- Write latency: the stored value is visible on regOut 1 cycle after the edge. It is visible on dout with 0 cycles (bypass) in the writing cycle.
- pend, pend_cnt and rd_busy reflect a pend_set from the next cycle on. rd_busy clears in the same cycle the clearing write is presented, through the bypass term.
- No handshakes. All outputs are defined every cycle, with no X after the first reset edge.

## Test plan
- Reset, then fill: write register i with $random for i=0..31 on lane 0, reading the same address on all ports in the same cycle -> dout equals din (register 0 reads 0 when ZERO_REG=1). regOut matches the model after each edge.
- Exhaustive read: wr_en=0, sweep all 32x32 rd_reg pairs -> each dout equals the stored model value, and rd_busy=0.
- Lane collision: wr_reg0=wr_reg1=5, din0=0xAAAA0000, din1=0x5555FFFF -> dout on address 5 is 0x5555FFFF in that cycle, and register 5 holds 0x5555FFFF afterwards.
- Scoreboard:
  - pend_set on register 7 -> next cycle pend[7]=1, pend_cnt=1, rd_busy=1 on the port reading 7.
  - A lane-0 write to 7 with 0x1234 -> same cycle rd_busy=0 and dout=0x1234; next cycle pend[7]=0, pend_cnt=0.
- Set/clear race: pend_set=1 and a write to register 9 in the same cycle -> pend[9]=1 afterwards, pend_cnt increments, and register 9 holds the new data.
- Mid-operation reset: with registers filled and pend[3] set, assert rst_n=0 for one edge together with wr_en=2'b11 -> all regOut=0, pend=0, pend_cnt=0, and the writes are not applied.
